instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Write-side front end of the IF-stage instruction memory.
- Takes bytes from the debug-unit UART receiver and assembles them little-endian into instruction words.
- Drives the memory's write port with one single-cycle strobe per word until the HALT word has been written.
- Controls memory clear at load start and reports done/error status to the debug unit.

Parameters:
- WORD_SIZE_IN_BYTES, 4, bytes per instruction word; word width W = 8*WORD_SIZE_IN_BYTES.
- MEM_SIZE_IN_WORDS, 64, memory capacity in words, HALT included.
- HALT_INSTRUCTION, 32'hFFFF_FFFF, end-of-program marker, W bits.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes of a partially assembled word.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  single-cycle pulse that starts or restarts a load.
- i_rx_valid  in  1  single-cycle pulse: i_rx_data holds a new byte.
- i_rx_data  in  8  received byte.
- i_mem_full  in  1  full flag from instruction memory.
- o_clear  out  1  single-cycle memory clear pulse.
- o_instruction  out  W  word presented to memory; valid while o_instruction_write=1.
- o_instruction_write  out  1  single-cycle write strobe.
- o_busy  out  1  high in CLEAR, RECEIVE, WRITE.
- o_done  out  1  level: HALT written.
- o_error  out  1  level: load aborted.
- o_word_count  out  clog2(MEM_SIZE_IN_WORDS+1)  words written in the current load.

Behaviour:
- Reset (i_reset, async, active-high; clock i_clk):
  - State IDLE.
  - All outputs 0.
  - Byte counter, timeout counter and assembly register cleared.
- States: IDLE, CLEAR, RECEIVE, WRITE, DONE, ERROR.
- i_start in any state → CLEAR on the next edge. A partial word or in-flight load is discarded and o_done/o_error drop.
- CLEAR:
  - o_clear=1 for exactly one cycle.
  - byte_cnt=0, o_word_count=0, timeout counter=0.
  - Next state RECEIVE.
- RECEIVE:
  - On i_rx_valid, the byte goes into assembly bits [8*byte_cnt +: 8], so the first byte lands in [7:0]; byte_cnt increments.
  - When the byte completing the word arrives (byte_cnt==WORD_SIZE_IN_BYTES-1), the next state is WRITE and o_instruction is registered with the full word.
- WRITE (exactly one cycle):
  - o_instruction_write=1; o_word_count increments.
  - Word==HALT_INSTRUCTION → DONE.
  - Non-HALT word and o_word_count (after increment) == MEM_SIZE_IN_WORDS → ERROR, since no room remains for HALT.
  - Otherwise → RECEIVE.
  - Write-to-write spacing is at least WORD_SIZE_IN_BYTES cycles, which guarantees a low strobe between writes.
- i_rx_valid during WRITE is captured as byte 0 of the next word. Bytes are never dropped in RECEIVE or WRITE.
- i_mem_full=1 sampled in RECEIVE or WRITE → ERROR; in WRITE the strobe is suppressed that cycle.
- Timeout counter:
  - Runs only in RECEIVE with byte_cnt≠0; cleared on every accepted byte.
  - Reaching TIMEOUT_CYCLES → ERROR.
  - byte_cnt==0 waits indefinitely.
- DONE/ERROR: levels held; bytes ignored; exit only via i_start or reset.
- IDLE: bytes ignored.
- i_start and i_rx_valid in the same cycle: restart wins and the byte is dropped.
- Reset mid-load: immediate return to IDLE; the memory is not cleared by this block (the memory has its own reset).
- Latency: last byte at edge N → strobe high in cycle N+1 → status or next state at edge N+2.

Decomposition:
- Shared instruction-memory header holds:
  - BYTE_SIZE.
  - INSTRUCTION_HALT, which defaults HALT_INSTRUCTION.
  - Default WORD_SIZE_IN_BYTES and MEM_SIZE_IN_WORDS.
  - Loader state encodings and the state-width constant.
  - CLEAR/HIGH/LOW macros.
- One sub-module: instruction_word_assembler. It covers the byte counter, shift/insert, word_ready pulse and clear input. The FSM, counters and timeout stay in instruction_loader.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 0x78,0x56,0x34,0x12,0xFF,0xFF,0xFF,0xFF.
  - Response: o_clear pulse; writes 0x12345678 then 0xFFFFFFFF; o_word_count=2; o_done=1.
- Back-to-back bytes:
  - Stimulus: i_rx_valid held high for 8 consecutive cycles, the 5th of them arriving during WRITE.
  - Response: two correct words; no byte lost.
- Capacity overflow:
  - Stimulus: MEM_SIZE_IN_WORDS=4; four non-HALT words.
  - Response: four strobes, then o_error=1, o_done=0.
- Memory full:
  - Stimulus: i_mem_full forced 1 while the word's final byte arrives.
  - Response: no strobe; o_error=1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; two bytes, then silence.
  - Response: o_error=1 exactly 16 cycles after the second byte.
- Restart and reset:
  - Stimulus: i_start after 3 bytes.
  - Response: o_clear, byte_cnt=0, next 4 bytes form a clean word.
  - Stimulus: i_reset asserted mid-word.
  - Response: all outputs 0 immediately.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_loader_pkg
//  Description : Shared instruction-memory definitions: byte/word geometry,
//                HALT marker, loader state encodings and level macros.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef INSTRUCTION_LOADER_MACROS
`define INSTRUCTION_LOADER_MACROS
`define CLEAR '0
`define HIGH  1'b1
`define LOW   1'b0
`endif

package instruction_loader_pkg;

    localparam int          BYTE_SIZE                  = 8;
    localparam int          DEFAULT_WORD_SIZE_IN_BYTES = 4;
    localparam int          DEFAULT_MEM_SIZE_IN_WORDS  = 64;
    localparam logic [31:0] INSTRUCTION_HALT           = 32'hFFFF_FFFF;

    localparam int LOADER_STATE_WIDTH = 3;

    typedef enum logic [LOADER_STATE_WIDTH-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/instruction_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_word_assembler
//  Description : Packs incoming bytes little-endian into one instruction word.
//                word_ready flags the byte that completes the current word.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_word_assembler
    import instruction_loader_pkg::*;
#(
    parameter  int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
    localparam int W     = BYTE_SIZE * WORD_SIZE_IN_BYTES,
    localparam int CNT_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [BYTE_SIZE-1:0] byte_data,
    output logic [W-1:0]         word,
    output logic [CNT_W-1:0]     byte_cnt,
    output logic                 word_ready
);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_SIZE_IN_BYTES - 1);

    // The byte being accepted now is the final one of the word
    assign word_ready = byte_valid && (byte_cnt == LAST_BYTE);

    // Insert each byte at its little-endian slot and advance the byte counter
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            word     <= `CLEAR;
            byte_cnt <= `CLEAR;
        end else if (clear) begin
            word     <= `CLEAR;
            byte_cnt <= `CLEAR;
        end else if (byte_valid) begin
            word[BYTE_SIZE*byte_cnt +: BYTE_SIZE] <= byte_data;
            byte_cnt <= word_ready ? `CLEAR : byte_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_loader
//  Description : Write-side front end of the instruction memory. Assembles
//                UART bytes into words, strobes them into memory until HALT,
//                and reports busy/done/error to the debug unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter  int WORD_SIZE_IN_BYTES = DEFAULT_WORD_SIZE_IN_BYTES,
    parameter  int MEM_SIZE_IN_WORDS  = DEFAULT_MEM_SIZE_IN_WORDS,
    parameter  logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] HALT_INSTRUCTION = INSTRUCTION_HALT,
    parameter  int TIMEOUT_CYCLES     = 1_000_000,
    localparam int W       = BYTE_SIZE * WORD_SIZE_IN_BYTES,
    localparam int COUNT_W = $clog2(MEM_SIZE_IN_WORDS + 1),
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1),
    localparam int CNT_W   = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_rx_valid,
    input  logic [BYTE_SIZE-1:0] i_rx_data,
    input  logic                 i_mem_full,
    output logic                 o_clear,
    output logic [W-1:0]         o_instruction,
    output logic                 o_instruction_write,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [COUNT_W-1:0]   o_word_count
);

    localparam logic [COUNT_W-1:0] MEM_WORDS    = COUNT_W'(MEM_SIZE_IN_WORDS);
    localparam logic [TIMER_W-1:0] TIMER_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

    loader_state_t        state;
    loader_state_t        state_next;
    logic                 byte_accept;
    logic                 assembler_clear;
    logic                 word_ready;
    logic [CNT_W-1:0]     byte_cnt;
    logic [COUNT_W-1:0]   word_count;
    logic [COUNT_W-1:0]   word_count_inc;
    logic [TIMER_W-1:0]   timer;
    logic                 timer_expired;

    // Bytes enter only while loading; a simultaneous restart drops the byte
    assign byte_accept     = i_rx_valid && !i_start &&
                             ((state == ST_RECEIVE) || (state == ST_WRITE));
    assign assembler_clear = i_start || (state == ST_CLEAR);
    assign word_count_inc  = word_count + 1'b1;
    assign timer_expired   = (byte_cnt != '0) && !byte_accept && (timer == TIMER_LAST);
    assign o_word_count    = word_count;

    instruction_word_assembler #(
        .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES)
    ) u_assembler (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .clear      (assembler_clear),
        .byte_valid (byte_accept),
        .byte_data  (i_rx_data),
        .word       (o_instruction),
        .byte_cnt   (byte_cnt),
        .word_ready (word_ready)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state and status outputs; restart overrides every state
    always_comb begin
        state_next          = state;
        o_clear             = `LOW;
        o_instruction_write = `LOW;
        o_busy              = `LOW;
        o_done              = `LOW;
        o_error             = `LOW;
        case (state)
            ST_IDLE: ;
            ST_CLEAR: begin
                o_clear    = `HIGH;
                o_busy     = `HIGH;
                state_next = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                o_busy = `HIGH;
                if (i_mem_full)         state_next = ST_ERROR;
                else if (word_ready)    state_next = ST_WRITE;
                else if (timer_expired) state_next = ST_ERROR;
            end
            ST_WRITE: begin
                o_busy              = `HIGH;
                o_instruction_write = !i_mem_full;
                if (i_mem_full)                            state_next = ST_ERROR;
                else if (o_instruction == HALT_INSTRUCTION) state_next = ST_DONE;
                else if (word_count_inc == MEM_WORDS)       state_next = ST_ERROR;
                else                                        state_next = ST_RECEIVE;
            end
            ST_DONE:  o_done  = `HIGH;
            ST_ERROR: o_error = `HIGH;
            default:  state_next = ST_IDLE;
        endcase
        if (i_start) state_next = ST_CLEAR;
    end

    // Words written in the current load; zeroed as soon as a load restarts
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                                word_count <= `CLEAR;
        else if (i_start || (state == ST_CLEAR))    word_count <= `CLEAR;
        else if (o_instruction_write)               word_count <= word_count_inc;
    end

    // Inter-byte idle timer, live only while a word is partially assembled
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                                               timer <= `CLEAR;
        else if (i_start || (state != ST_RECEIVE) || byte_accept)  timer <= `CLEAR;
        else if (byte_cnt != '0)                                   timer <= timer + 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_loader
//  Description : Directed self-checking bench for instruction_loader with a
//                four-word memory and a sixteen-cycle byte timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_full;
    logic        clear;
    logic [31:0] instruction;
    logic        instruction_write;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  word_count;

    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          clr_count = 0;
    logic [31:0] wr_words [32];
    int          base;
    int          base_clr;

    instruction_loader #(
        .WORD_SIZE_IN_BYTES (4),
        .MEM_SIZE_IN_WORDS  (4),
        .HALT_INSTRUCTION   (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_start             (start),
        .i_rx_valid          (rx_valid),
        .i_rx_data           (rx_data),
        .i_mem_full          (mem_full),
        .o_clear             (clear),
        .o_instruction       (instruction),
        .o_instruction_write (instruction_write),
        .o_busy              (busy),
        .o_done              (done),
        .o_error             (error),
        .o_word_count        (word_count)
    );

    always #5 clk = ~clk;

    // Log every memory write and clear pulse away from the active edge
    always @(negedge clk) begin
        if (instruction_write) begin
            if (wr_count < 32) wr_words[wr_count] = instruction;
            wr_count++;
        end
        if (clear) clr_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Pulse start, step through CLEAR and land in RECEIVE
    task automatic begin_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    logic [7:0] bb [8] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h8B};

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mem_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",  {31'd0, busy},  32'd0);
        check("reset_done",  {31'd0, done},  32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_count", {29'd0, word_count}, 32'd0);
        check("reset_instr", instruction, 32'd0);
        reset = 1'b0;
        tick();

        // Normal load with idle gaps between bytes
        base = wr_count; base_clr = clr_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clear_pulse", {31'd0, clear}, 32'd1);
        check("clear_busy",  {31'd0, busy},  32'd1);
        tick();
        check("clear_single", {31'd0, clear}, 32'd0);
        send_byte(8'h78); tick();
        send_byte(8'h56); tick();
        send_byte(8'h34); tick();
        send_byte(8'h12);
        check("strobe_latency", {31'd0, instruction_write}, 32'd1);
        check("strobe_word", instruction, 32'h1234_5678);
        tick();
        check("strobe_single", {31'd0, instruction_write}, 32'd0);
        check("count_after_w1", {29'd0, word_count}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hFF);
            tick();
        end
        tick();
        check("normal_writes", wr_count - base, 32'd2);
        check("normal_w0", wr_words[base], 32'h1234_5678);
        check("normal_w1", wr_words[base+1], 32'hFFFF_FFFF);
        check("normal_count", {29'd0, word_count}, 32'd2);
        check("normal_done", {31'd0, done}, 32'd1);
        check("normal_busy", {31'd0, busy}, 32'd0);
        check("normal_clears", clr_count - base_clr, 32'd1);
        send_byte(8'hAA); tick();
        check("done_ignores_bytes", {29'd0, word_count}, 32'd2);

        // Back-to-back bytes, fifth one lands during WRITE
        begin_load();
        check("restart_drops_done", {31'd0, done}, 32'd0);
        base = wr_count;
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = bb[i];
            tick();
        end
        rx_valid = 1'b0;
        tick();
        check("b2b_writes", wr_count - base, 32'd2);
        check("b2b_w0", wr_words[base], 32'hDEAD_BEEF);
        check("b2b_w1", wr_words[base+1], 32'h8BAD_F00D);
        check("b2b_count", {29'd0, word_count}, 32'd2);
        check("b2b_busy", {31'd0, busy}, 32'd1);

        // Capacity overflow: four non-HALT words fill a four-word memory
        begin_load();
        base = wr_count;
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'h10 + i);
            tick();
        end
        rx_valid = 1'b0;
        tick();
        check("cap_writes", wr_count - base, 32'd4);
        check("cap_last_word", wr_words[base+3], 32'h1F1E_1D1C);
        check("cap_error", {31'd0, error}, 32'd1);
        check("cap_done", {31'd0, done}, 32'd0);
        check("cap_count", {29'd0, word_count}, 32'd4);

        // Memory full while the final byte arrives
        begin_load();
        base = wr_count;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        mem_full = 1'b1;
        send_byte(8'h04);
        mem_full = 1'b0;
        tick();
        check("full_rx_error", {31'd0, error}, 32'd1);
        check("full_rx_writes", wr_count - base, 32'd0);

        // Memory full during the WRITE cycle suppresses the strobe
        begin_load();
        base = wr_count;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        mem_full = 1'b1;
        #1;
        check("full_wr_strobe", {31'd0, instruction_write}, 32'd0);
        tick();
        mem_full = 1'b0;
        check("full_wr_error", {31'd0, error}, 32'd1);
        check("full_wr_writes", wr_count - base, 32'd0);
        check("full_wr_count", {29'd0, word_count}, 32'd0);

        // No partial word: wait indefinitely, then timeout after two bytes
        begin_load();
        repeat (40) tick();
        check("idle_no_timeout", {31'd0, error}, 32'd0);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (15) tick();
        check("timeout_early", {31'd0, error}, 32'd0);
        tick();
        check("timeout_fire", {31'd0, error}, 32'd1);

        // Restart after three bytes, with a byte in the same cycle as start
        begin_load();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        tick();
        start = 1'b0; rx_valid = 1'b0;
        check("restart_clear", {31'd0, clear}, 32'd1);
        check("restart_byte_cnt", {30'd0, dut.byte_cnt}, 32'd0);
        tick();
        base = wr_count;
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        check("restart_word", instruction, 32'h1122_3344);
        tick();
        check("restart_writes", wr_count - base, 32'd1);

        // Asynchronous reset mid-word
        send_byte(8'h55); send_byte(8'h66);
        #2;
        reset = 1'b1;
        #1;
        check("async_busy",  {31'd0, busy}, 32'd0);
        check("async_count", {29'd0, word_count}, 32'd0);
        check("async_instr", instruction, 32'd0);
        tick();
        reset = 1'b0;
        base = wr_count;
        for (int i = 0; i < 4; i++) send_byte(8'h77);
        tick();
        check("idle_ignores_bytes", wr_count - base, 32'd0);
        check("idle_not_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
